// File: rtl/tt_uio_arb_pkg.sv
// Shared types and constants for the uio pin-bank arbiter.
package tt_uio_arb_pkg;

  localparam int UIO_W = 8;

  localparam logic [UIO_W-1:0] OE_DRIVE = 8'hFF;
  localparam logic [UIO_W-1:0] OE_HIZ   = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    OWN  = 2'd2
  } arb_state_e;

  // Increment an 8-bit counter, holding at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tt_rr_pick.sv
// Rotating-priority picker: returns the first set request strictly after ptr,
// wrapping around, as both a one-hot vector and an index.
module tt_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] pos;

  // Scan ptr+1, ptr+2, ... (mod N) and keep the first requester found.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    pos    = '0;
    for (int k = 1; k <= N; k++) begin
      pos = IDX_W'((int'(ptr) + k) % N);
      if (!valid && req[pos]) begin
        valid       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = pos;
      end
    end
  end

endmodule

// File: rtl/tt_uio_arbiter.sv
// Round-robin arbiter sharing the 8-bit bidirectional uio pin bank between
// NUM_REQ requesters, with bounded bursts and high-Z turnaround cycles on
// every change of bus direction.
// Optional feature: define UIO_ARB_LOCK_EN to let lock[w] suppress the
// BURST_MAX limit for the current owner.
module tt_uio_arbiter
  import tt_uio_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int BURST_MAX   = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       dir,
  input  logic [NUM_REQ-1:0]       lock,
  input  logic [UIO_W*NUM_REQ-1:0] wdata,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [UIO_W-1:0]         rdata,
  output logic                     rvalid,
  output logic                     busy,
  input  logic [UIO_W-1:0]         uio_in,
  output logic [UIO_W-1:0]         uio_out,
  output logic [UIO_W-1:0]         uio_oe
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   owner_q;
  logic               own_dir_q;
  logic               cur_dir_q;
  logic [1:0]         turn_cnt_q;
  logic [7:0]         beat_cnt_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [UIO_W-1:0]   uio_out_q;
  logic [UIO_W-1:0]   uio_oe_q;
  logic [UIO_W-1:0]   rdata_q;
  logic               rvalid_q;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  logic               start_direct;
  logic               start_turn;
  logic               turn_done;
  logic               beat;
  logic               own_exit;
  logic               lock_hold;
  logic [NUM_REQ-1:0] owner_onehot;
  logic [UIO_W-1:0]   wbyte [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_wbyte
    assign wbyte[g] = wdata[g*UIO_W +: UIO_W];
  end

  assign owner_onehot = NUM_REQ'(1) << owner_q;

`ifdef UIO_ARB_LOCK_EN
  assign lock_hold = lock[owner_q];
`else
  logic unused_lock;
  assign lock_hold   = 1'b0;
  assign unused_lock = ^lock;
`endif

  tt_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_direct)    state_d = OWN;
        else if (start_turn) state_d = TURN;
      end
      TURN:    if (turn_done) state_d = OWN;
      OWN:     if (own_exit)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/control decode shared by the FSM and the datapath registers.
  always_comb begin
    busy         = (state_q != IDLE);
    start_direct = (state_q == IDLE) && pick_valid && (dir[pick_idx] == cur_dir_q);
    start_turn   = (state_q == IDLE) && pick_valid && (dir[pick_idx] != cur_dir_q);
    turn_done    = (state_q == TURN) && (turn_cnt_q == 2'd0);
    beat         = (state_q == OWN) && gnt_q[owner_q] && req[owner_q];
    // A beat on the last allowed count ends the grant on that same edge.
    own_exit     = (state_q == OWN) &&
                   (!req[owner_q] ||
                    ((beat_cnt_q >= 8'(BURST_MAX - 1)) && !lock_hold));
  end

  // Grant, counters, direction tracking and pin registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
      owner_q    <= '0;
      own_dir_q  <= 1'b0;
      cur_dir_q  <= 1'b0;
      turn_cnt_q <= '0;
      beat_cnt_q <= '0;
      gnt_q      <= '0;
      uio_out_q  <= '0;
      uio_oe_q   <= OE_HIZ;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      if (start_direct || start_turn) begin
        owner_q    <= pick_idx;
        own_dir_q  <= dir[pick_idx];
        beat_cnt_q <= '0;
      end
      if (start_direct) gnt_q <= pick_onehot;
      if (start_turn) begin
        turn_cnt_q <= 2'(TURN_CYCLES - 1);
        uio_oe_q   <= OE_HIZ;
      end
      if (state_q == TURN) begin
        if (turn_done) begin
          gnt_q     <= owner_onehot;
          cur_dir_q <= own_dir_q;
        end else begin
          turn_cnt_q <= turn_cnt_q - 2'd1;
        end
      end
      if (beat) begin
        beat_cnt_q <= sat_inc8(beat_cnt_q);
        if (own_dir_q) begin
          uio_out_q <= wbyte[owner_q];
          uio_oe_q  <= OE_DRIVE;
        end else begin
          rdata_q  <= uio_in;
          rvalid_q <= 1'b1;
        end
      end
      if (own_exit) begin
        gnt_q    <= '0;
        rr_ptr_q <= owner_q;
      end
    end
  end

  assign gnt     = gnt_q;
  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign uio_out = uio_out_q;
  assign uio_oe  = uio_oe_q;

endmodule

// File: tb/tb_tt_uio_arbiter.sv
// Self-checking bench for tt_uio_arbiter. Each scenario is described as a
// number of pending beats per requester; a grant-schedule model derives the
// expected per-cycle grants and pin activity from the arbitration rules.
module tb_tt_uio_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int BURST_MAX   = 8;
  localparam int TURN_CYCLES = 1;
  localparam int MAXC        = 512;
`ifdef UIO_ARB_LOCK_EN
  localparam bit LOCK_MODEL = 1'b1;
`else
  localparam bit LOCK_MODEL = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req, dir, lock;
  logic [8*NUM_REQ-1:0] wdata;
  logic [NUM_REQ-1:0]   gnt;
  logic [7:0]           rdata, uio_in, uio_out, uio_oe;
  logic                 rvalid, busy;

  always #5 clk = ~clk;

  tt_uio_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .BURST_MAX   (BURST_MAX),
    .TURN_CYCLES (TURN_CYCLES)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .dir     (dir),
    .lock    (lock),
    .wdata   (wdata),
    .gnt     (gnt),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .busy    (busy),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Scenario description.
  int                 sc_rem [NUM_REQ];
  logic [NUM_REQ-1:0] sc_dir, sc_lock;
  bit                 sc_rand_dir;

  // Per-cycle stimulus and expectations.
  logic [NUM_REQ-1:0] s_req   [MAXC];
  logic [NUM_REQ-1:0] s_dir   [MAXC];
  logic [7:0]         s_uin   [MAXC];
  logic [7:0]         s_wd    [NUM_REQ][MAXC];
  logic [NUM_REQ-1:0] e_gnt   [MAXC];
  logic               e_busy  [MAXC];
  logic               e_rv    [MAXC];
  logic [7:0]         e_oe    [MAXC];
  logic [7:0]         e_out   [MAXC];
  logic [7:0]         e_rd    [MAXC];
  bit                 ev_oe   [MAXC];
  bit                 ev_out  [MAXC];
  bit                 ev_rd   [MAXC];
  logic [7:0]         ev_oe_v [MAXC];
  logic [7:0]         ev_out_v[MAXC];
  logic [7:0]         ev_rd_v [MAXC];

  // Observed grant episodes (owner, beats) from the last scenario.
  int obs_owner[$];
  int obs_beats[$];

  task automatic clear_scenario();
    for (int i = 0; i < NUM_REQ; i++) sc_rem[i] = 0;
    sc_dir      = '0;
    sc_lock     = '0;
    sc_rand_dir = 1'b0;
  endtask

  // Holds reset for n edges with every requester asking; returns just after
  // the last reset edge so the caller's cycle 0 starts in the reset state.
  task automatic apply_reset(input int n);
    rst_n  = 1'b0;
    req    = '1;
    dir    = NUM_REQ'($urandom);
    lock   = NUM_REQ'($urandom);
    wdata  = {$urandom, $urandom} & {(8*NUM_REQ){1'b1}};
    uio_in = 8'($urandom);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_tests++;
      if (gnt !== '0 || uio_oe !== 8'h00 || uio_out !== 8'h00 ||
          rvalid !== 1'b0 || busy !== 1'b0 || rdata !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_state: gnt=%b oe=%h out=%h rvalid=%b busy=%b rdata=%h, expected all zero",
                 gnt, uio_oe, uio_out, rvalid, busy, rdata);
      end
    end
    @(posedge clk); #1;
  endtask

  // Builds the grant schedule for the current scenario, then drives it and
  // compares every cycle. Stops early (before driving cycle abort_at) if
  // abort_at >= 0.
  task automatic run_scenario(input int abort_at);
    int   rem [NUM_REQ];
    int   rel [NUM_REQ];
    int   t, ptr, w, pos, turn, start, nb, glen, end_c, cur_len, cur_own;
    logic d, bus;
    logic [7:0] cur_oe, cur_out, cur_rd;
    logic [NUM_REQ-1:0] prev_gnt;

    for (int c = 0; c < MAXC; c++) begin
      s_dir[c]  = sc_rand_dir ? NUM_REQ'($urandom) : sc_dir;
      s_uin[c]  = 8'($urandom);
      for (int i = 0; i < NUM_REQ; i++) s_wd[i][c] = 8'($urandom);
      e_gnt[c]  = '0;
      e_busy[c] = 1'b0;
      e_rv[c]   = 1'b0;
      ev_oe[c]  = 1'b0;
      ev_out[c] = 1'b0;
      ev_rd[c]  = 1'b0;
    end

    for (int i = 0; i < NUM_REQ; i++) begin
      rem[i] = sc_rem[i];
      rel[i] = 0;
    end
    t   = 0;
    ptr = NUM_REQ - 1;
    bus = 1'b0;
    for (int g = 0; g < 64; g++) begin
      w = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        pos = (ptr + k) % NUM_REQ;
        if (w < 0 && rem[pos] > 0) w = pos;
      end
      if (w < 0) break;
      d     = s_dir[t][w];
      turn  = (d != bus) ? TURN_CYCLES : 0;
      start = t + 1 + turn;
      if (turn > 0) begin
        ev_oe[t+1]   = 1'b1;
        ev_oe_v[t+1] = 8'h00;
      end
      bus = d;
      if (LOCK_MODEL && sc_lock[w]) nb = rem[w];
      else                          nb = (rem[w] < BURST_MAX) ? rem[w] : BURST_MAX;
      // A full burst ends on its last beat; anything else needs one more
      // cycle in which the requester has already dropped req.
      glen = (nb == BURST_MAX && !(LOCK_MODEL && sc_lock[w])) ? nb : nb + 1;
      for (int c = t + 1; c < start + glen; c++) e_busy[c] = 1'b1;
      for (int c = start; c < start + glen; c++) e_gnt[c] = NUM_REQ'(1) << w;
      for (int b = 0; b < nb; b++) begin
        if (d) begin
          ev_out[start+b+1]   = 1'b1;
          ev_out_v[start+b+1] = s_wd[w][start+b];
          ev_oe[start+b+1]    = 1'b1;
          ev_oe_v[start+b+1]  = 8'hFF;
        end else begin
          ev_rd[start+b+1]    = 1'b1;
          ev_rd_v[start+b+1]  = s_uin[start+b];
          e_rv[start+b+1]     = 1'b1;
        end
      end
      rem[w] -= nb;
      if (rem[w] == 0) rel[w] = start + nb;
      t   = start + glen;
      ptr = w;
    end
    end_c = t + 2;

    cur_oe = 8'h00; cur_out = 8'h00; cur_rd = 8'h00;
    for (int c = 0; c <= end_c; c++) begin
      if (ev_oe[c])  cur_oe  = ev_oe_v[c];
      if (ev_out[c]) cur_out = ev_out_v[c];
      if (ev_rd[c])  cur_rd  = ev_rd_v[c];
      e_oe[c]  = cur_oe;
      e_out[c] = cur_out;
      e_rd[c]  = cur_rd;
      for (int i = 0; i < NUM_REQ; i++) s_req[c][i] = (sc_rem[i] > 0) && (c < rel[i]);
    end

    obs_owner.delete();
    obs_beats.delete();
    prev_gnt = '0;
    cur_len  = 0;
    cur_own  = -1;
    for (int c = 0; c <= end_c; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (c == abort_at) return;
      rst_n  = 1'b1;
      req    = s_req[c];
      dir    = s_dir[c];
      lock   = sc_lock;
      uio_in = s_uin[c];
      for (int i = 0; i < NUM_REQ; i++) wdata[8*i +: 8] = s_wd[i][c];
      @(negedge clk);

      if (gnt != '0) begin
        if (prev_gnt == '0) begin
          for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) cur_own = i;
          obs_owner.push_back(cur_own);
          cur_len = 0;
        end
        if ((gnt & req) != '0) cur_len++;
      end else if (prev_gnt != '0) begin
        obs_beats.push_back(cur_len);
      end
      prev_gnt = gnt;

      n_tests++;
      if (gnt !== e_gnt[c]) begin
        n_fail++;
        $display("FAIL gnt cycle %0d: got %b expected %b", c, gnt, e_gnt[c]);
      end
      n_tests++;
      if (busy !== e_busy[c]) begin
        n_fail++;
        $display("FAIL busy cycle %0d: got %b expected %b", c, busy, e_busy[c]);
      end
      n_tests++;
      if (uio_oe !== e_oe[c]) begin
        n_fail++;
        $display("FAIL uio_oe cycle %0d: got %h expected %h", c, uio_oe, e_oe[c]);
      end
      n_tests++;
      if (uio_out !== e_out[c]) begin
        n_fail++;
        $display("FAIL uio_out cycle %0d: got %h expected %h", c, uio_out, e_out[c]);
      end
      n_tests++;
      if (rvalid !== e_rv[c]) begin
        n_fail++;
        $display("FAIL rvalid cycle %0d: got %b expected %b", c, rvalid, e_rv[c]);
      end
      n_tests++;
      if (rdata !== e_rd[c]) begin
        n_fail++;
        $display("FAIL rdata cycle %0d: got %h expected %h", c, rdata, e_rd[c]);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset(4);
  endtask

  task automatic test_read();
    clear_scenario();
    sc_rem[0] = 1;
    run_scenario(-1);
    n_tests++;
    if (rdata !== s_uin[1]) begin
      n_fail++;
      $display("FAIL read_hold: rdata got %h expected %h", rdata, s_uin[1]);
    end
    apply_reset(1);
  endtask

  task automatic test_write_turn();
    clear_scenario();
    sc_rem[1] = 1;
    sc_dir[1] = 1'b1;
    run_scenario(-1);
    n_tests++;
    if (uio_oe !== 8'hFF || uio_out !== s_wd[1][2]) begin
      n_fail++;
      $display("FAIL write_hold: oe/out got %h/%h expected ff/%h", uio_oe, uio_out, s_wd[1][2]);
    end
    apply_reset(1);
  endtask

  task automatic test_round_robin();
    clear_scenario();
    for (int i = 0; i < NUM_REQ; i++) sc_rem[i] = 2 * BURST_MAX;
    run_scenario(-1);
    n_tests++;
    if (obs_owner.size() != 2 * NUM_REQ) begin
      n_fail++;
      $display("FAIL rr_count: got %0d grants expected %0d", obs_owner.size(), 2 * NUM_REQ);
    end else begin
      for (int k = 0; k < 2 * NUM_REQ; k++) begin
        n_tests++;
        if (obs_owner[k] != k % NUM_REQ || obs_beats[k] != BURST_MAX) begin
          n_fail++;
          $display("FAIL rr_order grant %0d: owner %0d beats %0d expected owner %0d beats %0d",
                   k, obs_owner[k], obs_beats[k], k % NUM_REQ, BURST_MAX);
        end
      end
    end
    apply_reset(1);
  endtask

  task automatic test_burst_lock();
    int exp_first;
    clear_scenario();
    sc_rem[2]  = 20;
    sc_lock[2] = 1'b1;
    run_scenario(-1);
    exp_first = LOCK_MODEL ? 20 : BURST_MAX;
    n_tests++;
    if (obs_beats.size() == 0 || obs_beats[0] != exp_first) begin
      n_fail++;
      $display("FAIL burst_len: first grant beats %0d expected %0d",
               (obs_beats.size() == 0) ? -1 : obs_beats[0], exp_first);
    end
    apply_reset(1);
  endtask

  task automatic test_reset_mid_burst();
    clear_scenario();
    sc_rem[2] = BURST_MAX;
    sc_dir[2] = 1'b1;
    // Beats land in cycles 2,3,4; beat 3 is on the pins in cycle 5.
    run_scenario(5);
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (uio_oe !== 8'hFF || uio_out !== s_wd[2][4] || gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL pre_reset: oe/out/gnt got %h/%h/%b expected ff/%h/0100",
               uio_oe, uio_out, gnt, s_wd[2][4]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (uio_oe !== 8'h00 || gnt !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: oe/gnt/busy got %h/%b/%b expected 00/0000/0", uio_oe, gnt, busy);
    end
    apply_reset(1);
    clear_scenario();
    sc_rem[0] = 3;
    sc_rem[2] = 3;
    run_scenario(-1);
    n_tests++;
    if (obs_owner.size() == 0 || obs_owner[0] != 0) begin
      n_fail++;
      $display("FAIL after_reset_first: owner %0d expected 0",
               (obs_owner.size() == 0) ? -1 : obs_owner[0]);
    end
    apply_reset(1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      clear_scenario();
      for (int i = 0; i < NUM_REQ; i++) sc_rem[i] = int'($urandom_range(0, 20));
      sc_lock     = NUM_REQ'($urandom);
      sc_rand_dir = 1'b1;
      run_scenario(-1);
      apply_reset(1);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    req    = '0;
    dir    = '0;
    lock   = '0;
    wdata  = '0;
    uio_in = '0;
    test_reset();
    test_read();
    test_write_turn();
    test_round_robin();
    test_burst_lock();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
